// File: rtl/chip_ledger_pkg.sv
`default_nettype none
// ============================================================================
// Module  : chip_ledger_pkg
// Purpose : Shared opcode, FSM state and default constants for the chip
//           ledger that owns every chip on the two-player table.
// Revision: 1.0 - initial release
// ============================================================================
package chip_ledger_pkg;

   // Betting commands issued by the game FSM; only 3'd7 is undefined.
   typedef enum logic [2:0] {
      NEW_GAME = 3'd0,
      BET      = 3'd1,
      CALL     = 3'd2,
      FOLD     = 3'd3,
      COLLECT  = 3'd4,
      AWARD    = 3'd5,
      SPLIT    = 3'd6
   } ledger_op_t;

   // Command sequencer states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EXEC  = 3'd1,
      COLL0 = 3'd2,
      COLL1 = 3'd3,
      RESP  = 3'd4
   } ledger_state_t;

   localparam int LEDGER_START_STACK = 1000;
   localparam int LEDGER_AMT_W       = 11;

endpackage : chip_ledger_pkg
`default_nettype wire

// File: rtl/chip_ledger.sv
`default_nettype none
// ============================================================================
// Module  : chip_ledger
// Purpose : Sequential chip accounting engine. Accepts one betting command at
//           a time over valid/ready, applies it atomically to the stacks,
//           per-round pots and collected pot, then pulses a response.
// Revision: 1.0 - initial release
// ============================================================================
module chip_ledger
   import chip_ledger_pkg::*;
#(
   parameter int START_STACK = LEDGER_START_STACK,
   parameter int AMT_W       = LEDGER_AMT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic             cmd_player,
   input  logic [AMT_W-1:0] cmd_amount,
   output logic [AMT_W-1:0] player_stacks [2],
   output logic [AMT_W-1:0] player_pots   [2],
   output logic [AMT_W-1:0] pot_size,
   output logic             resp_valid,
   output logic             resp_err,
   output logic             resp_allin
);

   localparam logic [AMT_W-1:0] START_AMT = AMT_W'(START_STACK);

   ledger_state_t    state, state_nxt;

   // Command fields captured at acceptance so the inputs may move afterwards.
   ledger_op_t       op_lat;
   logic             player_lat;
   logic [AMT_W-1:0] amount_lat;
   logic             opp;

   logic [AMT_W-1:0] stacks_nxt [2];
   logic [AMT_W-1:0] pots_nxt   [2];
   logic [AMT_W-1:0] pot_nxt;
   logic             err_nxt;
   logic             allin_nxt;

   logic [AMT_W-1:0] move;
   logic [AMT_W-1:0] owed;
   logic [AMT_W-1:0] half;
   logic [AMT_W:0]   fold_sum;
   logic [AMT_W:0]   fold_total;

   // Chips actually moved: what was asked for, limited by what the player has.
   function automatic logic [AMT_W-1:0] clamp_xfer(input logic [AMT_W-1:0] want,
                                                   input logic [AMT_W-1:0] avail);
      return (want < avail) ? want : avail;
   endfunction

   assign opp       = ~player_lat;
   assign cmd_ready = (state == IDLE);

   // Sequencer state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus the post-command ledger values and response flags.
   always_comb begin
      state_nxt  = state;
      stacks_nxt = player_stacks;
      pots_nxt   = player_pots;
      pot_nxt    = pot_size;
      err_nxt    = 1'b0;
      move       = '0;
      owed       = '0;
      half       = '0;
      fold_sum   = '0;
      fold_total = '0;

      case (state)
         IDLE: begin
            if (cmd_valid) state_nxt = EXEC;
         end

         EXEC: begin
            state_nxt = (op_lat == COLLECT) ? COLL0 : RESP;
            case (op_lat)
               NEW_GAME: begin
                  stacks_nxt[0] = START_AMT;
                  stacks_nxt[1] = START_AMT;
                  pots_nxt[0]   = '0;
                  pots_nxt[1]   = '0;
                  pot_nxt       = '0;
               end
               BET: begin
                  if (amount_lat == '0) begin
                     err_nxt = 1'b1;
                  end else begin
                     move                   = clamp_xfer(amount_lat, player_stacks[player_lat]);
                     stacks_nxt[player_lat] = player_stacks[player_lat] - move;
                     pots_nxt[player_lat]   = player_pots[player_lat] + move;
                  end
               end
               CALL: begin
                  // A zero shortfall is a check and moves nothing.
                  if (player_pots[opp] > player_pots[player_lat])
                     owed = player_pots[opp] - player_pots[player_lat];
                  move                   = clamp_xfer(owed, player_stacks[player_lat]);
                  stacks_nxt[player_lat] = player_stacks[player_lat] - move;
                  pots_nxt[player_lat]   = player_pots[player_lat] + move;
               end
               FOLD: begin
                  fold_sum   = {1'b0, pot_size} + {1'b0, player_pots[0]} + {1'b0, player_pots[1]};
                  fold_total = {1'b0, player_stacks[opp]} + fold_sum;
                  // Conservation keeps the carry clear; saturate rather than wrap if it ever sets.
                  stacks_nxt[opp] = fold_total[AMT_W] ? {AMT_W{1'b1}} : fold_total[AMT_W-1:0];
                  pots_nxt[0]     = '0;
                  pots_nxt[1]     = '0;
                  pot_nxt         = '0;
               end
               COLLECT: begin
                  // Work happens in the two collection states.
               end
               AWARD: begin
                  if (player_pots[0] != '0 || player_pots[1] != '0) begin
                     err_nxt = 1'b1;
                  end else begin
                     stacks_nxt[player_lat] = player_stacks[player_lat] + pot_size;
                     pot_nxt                = '0;
                  end
               end
               SPLIT: begin
                  if (player_pots[0] != '0 || player_pots[1] != '0) begin
                     err_nxt = 1'b1;
                  end else begin
                     half                   = pot_size >> 1;
                     stacks_nxt[0]          = player_stacks[0] + half;
                     stacks_nxt[1]          = player_stacks[1] + half;
                     // Odd chip goes to the acting player.
                     stacks_nxt[player_lat] = stacks_nxt[player_lat] + {{(AMT_W-1){1'b0}}, pot_size[0]};
                     pot_nxt                = '0;
                  end
               end
               default: begin
                  err_nxt = 1'b1;
               end
            endcase
         end

         COLL0: begin
            pot_nxt     = pot_size + player_pots[0];
            pots_nxt[0] = '0;
            state_nxt   = COLL1;
         end

         COLL1: begin
            pot_nxt     = pot_size + player_pots[1];
            pots_nxt[1] = '0;
            state_nxt   = RESP;
         end

         RESP: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      allin_nxt = !err_nxt && (stacks_nxt[player_lat] == '0);
   end

   // Capture the command fields on the accepting edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_lat     <= NEW_GAME;
         player_lat <= 1'b0;
         amount_lat <= '0;
      end else if (state == IDLE && cmd_valid) begin
         op_lat     <= ledger_op_t'(cmd_op);
         player_lat <= cmd_player;
         amount_lat <= cmd_amount;
      end
   end

   // Ledger registers and the one-cycle response, all updated together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         player_stacks[0] <= START_AMT;
         player_stacks[1] <= START_AMT;
         player_pots[0]   <= '0;
         player_pots[1]   <= '0;
         pot_size         <= '0;
         resp_valid       <= 1'b0;
         resp_err         <= 1'b0;
         resp_allin       <= 1'b0;
      end else begin
         player_stacks <= stacks_nxt;
         player_pots   <= pots_nxt;
         pot_size      <= pot_nxt;
         resp_valid    <= (state_nxt == RESP);
         resp_err      <= (state_nxt == RESP) && err_nxt;
         resp_allin    <= (state_nxt == RESP) && allin_nxt;
      end
   end

endmodule : chip_ledger
`default_nettype wire

// File: tb/tb_chip_ledger.sv
`default_nettype none
// ============================================================================
// Module  : tb_chip_ledger
// Purpose : Self-checking bench for chip_ledger: directed table scenarios then
//           randomized commands against a chip-accounting reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_chip_ledger;

   localparam int START = 1000;
   localparam int TOTAL = 2 * START;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic        cmd_player;
   logic [10:0] cmd_amount;
   logic [10:0] player_stacks [2];
   logic [10:0] player_pots   [2];
   logic [10:0] pot_size;
   logic        resp_valid;
   logic        resp_err;
   logic        resp_allin;

   int compared;
   int mismatched;

   // Reference ledger in plain integers.
   int mstk [2];
   int mpt  [2];
   int mpot;

   chip_ledger dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_player    (cmd_player),
      .cmd_amount    (cmd_amount),
      .player_stacks (player_stacks),
      .player_pots   (player_pots),
      .pot_size      (pot_size),
      .resp_valid    (resp_valid),
      .resp_err      (resp_err),
      .resp_allin    (resp_allin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      mstk[0] = START; mstk[1] = START;
      mpt[0]  = 0;     mpt[1]  = 0;
      mpot    = 0;
   endtask

   // Chip rules applied to the reference ledger.
   task automatic model_apply(input int op, input int p, input int amt,
                              output bit err, output bit allin);
      int o, m, d;
      o   = 1 - p;
      err = 0;
      case (op)
         0: model_reset();
         1: begin
            if (amt == 0) err = 1;
            else begin
               m = (amt < mstk[p]) ? amt : mstk[p];
               mstk[p] -= m; mpt[p] += m;
            end
         end
         2: begin
            d = mpt[o] - mpt[p];
            if (d < 0) d = 0;
            m = (d < mstk[p]) ? d : mstk[p];
            mstk[p] -= m; mpt[p] += m;
         end
         3: begin
            mstk[o] += mpot + mpt[0] + mpt[1];
            mpt[0] = 0; mpt[1] = 0; mpot = 0;
         end
         4: begin
            mpot += mpt[0] + mpt[1];
            mpt[0] = 0; mpt[1] = 0;
         end
         5: begin
            if (mpt[0] != 0 || mpt[1] != 0) err = 1;
            else begin mstk[p] += mpot; mpot = 0; end
         end
         6: begin
            if (mpt[0] != 0 || mpt[1] != 0) err = 1;
            else begin
               mstk[0] += mpot / 2; mstk[1] += mpot / 2;
               mstk[p] += mpot % 2; mpot = 0;
            end
         end
         default: err = 1;
      endcase
      allin = !err && (mstk[p] == 0);
   endtask

   task automatic chk_ledger(input string tag);
      chk({tag, ".stack0"}, 32'(player_stacks[0]), mstk[0]);
      chk({tag, ".stack1"}, 32'(player_stacks[1]), mstk[1]);
      chk({tag, ".pot0"},   32'(player_pots[0]),   mpt[0]);
      chk({tag, ".pot1"},   32'(player_pots[1]),   mpt[1]);
      chk({tag, ".potsz"},  32'(pot_size),         mpot);
      chk({tag, ".conserve"}, 32'(player_stacks[0]) + 32'(player_stacks[1]) + 32'(player_pots[0])
                            + 32'(player_pots[1]) + 32'(pot_size), TOTAL);
   endtask

   // One full command: present, wait acceptance, scramble inputs while busy,
   // then check latency, response and ledger contents at the response pulse.
   task automatic do_cmd(input string tag, input int op, input int p, input int amt);
      int lat;
      bit exp_err, exp_allin, ready_leak;
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_op     = 3'(op);
      cmd_player = p[0];
      cmd_amount = 11'(amt);
      lat = 0;
      while (!cmd_ready && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".ready"}, 32'(cmd_ready), 1);
      model_apply(op, p, amt, exp_err, exp_allin);
      lat        = 0;
      ready_leak = 0;
      do begin
         @(negedge clk);
         lat++;
         cmd_op     = 3'($urandom);
         cmd_player = 1'($urandom);
         cmd_amount = 11'($urandom);
         if (!resp_valid && cmd_ready) ready_leak = 1;
      end while (!resp_valid && lat < 12);
      chk({tag, ".latency"}, lat, (op == 4) ? 4 : 2);
      chk({tag, ".busy_ready"}, 32'(ready_leak), 0);
      chk({tag, ".err"},   32'(resp_err),   32'(exp_err));
      chk({tag, ".allin"}, 32'(resp_allin), 32'(exp_allin));
      chk_ledger(tag);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".pulse"}, 32'(resp_valid), 0);
   endtask

   initial begin
      int op, p, amt, r;
      compared   = 0;
      mismatched = 0;
      reset_n    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_player = 1'b0;
      cmd_amount = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset state.
      chk("rst.ready", 32'(cmd_ready), 1);
      chk("rst.rvalid", 32'(resp_valid), 0);
      chk("rst.rerr", 32'(resp_err), 0);
      chk("rst.rallin", 32'(resp_allin), 0);
      chk_ledger("rst");

      // Opening bet and calls.
      do_cmd("bet50", 1, 0, 50);
      chk("bet50.s0", 32'(player_stacks[0]), 950);
      do_cmd("call1", 2, 1, 0);
      chk("call1.s1", 32'(player_stacks[1]), 950);
      do_cmd("check1", 2, 1, 0);

      // Collect into the pot, valid held high across the whole command.
      do_cmd("collect", 4, 0, 0);
      chk("collect.pot", 32'(pot_size), 100);

      // Clamped all-in bet, then a rejected zero bet.
      do_cmd("bet2000", 1, 0, 2000);
      chk("bet2000.s0", 32'(player_stacks[0]), 0);
      do_cmd("bet0", 1, 0, 0);

      // Odd-sized pot split.
      do_cmd("new", 0, 0, 0);
      do_cmd("bet51", 1, 0, 51);
      do_cmd("bet50b", 1, 1, 50);
      do_cmd("collect101", 4, 1, 0);
      chk("collect101.pot", 32'(pot_size), 101);
      do_cmd("split", 6, 1, 0);
      chk("split.s0", 32'(player_stacks[0]), 999);
      chk("split.s1", 32'(player_stacks[1]), 1001);

      // Award refused while a round pot is open; undefined opcode refused.
      do_cmd("bet10", 1, 0, 10);
      do_cmd("award_bad", 5, 0, 0);
      do_cmd("op7", 7, 1, 5);
      do_cmd("fold", 3, 0, 0);

      // Reset during the second collection step.
      do_cmd("bet30", 1, 1, 30);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd4;
      cmd_player = 1'b0;
      @(negedge clk);   // EXEC
      cmd_valid = 1'b0;
      @(negedge clk);   // COLL0
      @(negedge clk);   // COLL1
      chk("abort.partial_pot", 32'(pot_size), mpot + mpt[0]);
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("abort.ready", 32'(cmd_ready), 1);
      chk("abort.rvalid", 32'(resp_valid), 0);
      chk_ledger("abort");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("abort.quiet", 32'(resp_valid), 0);

      // Randomized play.
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 99);
         if      (r < 35) op = 1;
         else if (r < 55) op = 2;
         else if (r < 67) op = 4;
         else if (r < 75) op = 3;
         else if (r < 83) op = 5;
         else if (r < 91) op = 6;
         else if (r < 95) op = 0;
         else             op = 7;
         p = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         if      (r == 0) amt = 0;
         else if (r < 3)  amt = $urandom_range(0, 2047);
         else             amt = $urandom_range(1, 80);
         do_cmd("rand", op, p, amt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_chip_ledger
`default_nettype wire
